palin_frame_tx: RTL and testbench

// - Serial palindrome frame transmitter. Accepts a parallel DATA_WIDTH-bit word over a valid/ready

---
 rtl/palin_frame_tx.sv | 142 ++++++++++++++
 tb/tb_palin_frame_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/palin_frame_tx.sv
// palin_frame_tx
//   Serial palindrome frame transmitter. A DATA_WIDTH-bit word accepted over a
//   valid/ready handshake is shifted out MSB-first, one bit per clock, followed
//   by its mirror image, so every frame on serial_out reads the same in both
//   directions. An optional run of idle gap bits follows each frame.
//
// Ports
//   clk         rising-edge clock, one serial bit per cycle
//   rst         asynchronous active-low reset
//   data_in     payload word, captured only on accept
//   data_valid  upstream holds a word
//   data_ready  high only while idle (registered)
//   serial_out  registered serial frame bit
//   frame_busy  high while a frame or gap bit is on serial_out
//   frame_done  one-cycle pulse with the last frame bit on serial_out
module palin_frame_tx #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ODD_FRAME  = 1,
  parameter int unsigned GAP_CYCLES = 2,
  parameter bit          IDLE_BIT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  serial_out,
  output logic                  frame_busy,
  output logic                  frame_done
);

  localparam int unsigned    IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_WIDTH - 1);
  // Odd frames send the centre bit once, so the mirror half starts one bit up.
  localparam logic [IW-1:0]  IDX_REV0 = (ODD_FRAME != 0) ? IW'(1) : '0;
  localparam logic [3:0]     GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;

  // Outputs are computed from the current state and registered, so each bit
  // appears on serial_out one edge after the state that selects it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    data_d   = data_q;
    serial_d = IDLE_BIT;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          data_d  = data_in;
          idx_d   = IDX_LAST;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        serial_d = data_q[idx_q];
        busy_d   = 1'b1;
        if (idx_q == '0) begin
          idx_d   = IDX_REV0;
          state_d = ST_REV;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_REV: begin
        serial_d = data_q[idx_q];
        busy_d   = 1'b1;
        if (idx_q == IDX_LAST) begin
          done_d = 1'b1;
          idx_d  = '0;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        gap_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      serial_q <= IDLE_BIT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign serial_out = serial_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_palin_frame_tx.sv
`timescale 1ns/1ps
module tb_palin_frame_tx;

  localparam int unsigned W     = 3;
  localparam int unsigned A_ODD = 1;
  localparam int unsigned A_GAP = 2;
  localparam int unsigned A_L   = 2 * W - A_ODD;
  localparam int unsigned B_ODD = 0;
  localparam int unsigned B_GAP = 0;
  localparam int unsigned B_L   = 2 * W - B_ODD;
  localparam bit          IDLE  = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a_data, b_data;
  logic         a_valid, b_valid;
  logic         a_ready, a_serial, a_busy, a_done;
  logic         b_ready, b_serial, b_busy, b_done;

  always #5 clk = ~clk;

  palin_frame_tx #(.DATA_WIDTH(W), .ODD_FRAME(A_ODD), .GAP_CYCLES(A_GAP), .IDLE_BIT(IDLE)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data), .data_valid(a_valid), .data_ready(a_ready),
    .serial_out(a_serial), .frame_busy(a_busy), .frame_done(a_done)
  );

  palin_frame_tx #(.DATA_WIDTH(W), .ODD_FRAME(B_ODD), .GAP_CYCLES(B_GAP), .IDLE_BIT(IDLE)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data), .data_valid(b_valid), .data_ready(b_ready),
    .serial_out(b_serial), .frame_busy(b_busy), .frame_done(b_done)
  );

  typedef struct {
    int cyc;
    bit b;
    bit done;
  } exp_t;

  exp_t        sbq[$];
  int          cyc        = 0;
  int          busy_until = -100;
  int          n_acc      = 0;
  int          n_cmp      = 0;
  int          n_err      = 0;
  bit          rand_on    = 1'b0;
  bit          mon_on     = 1'b0;
  int          e_m;
  logic [31:0] f_m;
  exp_t        ent;
  logic [3:0]  exp_v;

  // Palindrome built from the word: MSB-first half, then the mirror of it
  // (dropping the centre bit for odd frames). Bit j of the result is frame bit j.
  function automatic logic [31:0] frame_bits(input logic [15:0] d, input int unsigned w,
                                              input int unsigned odd);
    logic [31:0] f;
    f = '0;
    for (int unsigned j = 0; j < w; j++) f[j] = d[w-1-j];
    for (int unsigned j = 0; j < w - odd; j++) f[w+j] = f[w-1-odd-j];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model for instance A: decides acceptance from its own notion of
  // readiness and queues the expected serial stream with absolute cycle stamps.
  always @(posedge clk) begin
    if (rst && a_valid && cyc > busy_until) begin
      e_m = cyc + 1;
      f_m = frame_bits(16'(a_data), W, A_ODD);
      for (int unsigned j = 0; j < A_L; j++) begin
        ent.cyc  = e_m + 1 + int'(j);
        ent.b    = f_m[j];
        ent.done = (j == A_L - 1);
        sbq.push_back(ent);
      end
      for (int unsigned j = 0; j < A_GAP; j++) begin
        ent.cyc  = e_m + 1 + int'(A_L) + int'(j);
        ent.b    = IDLE;
        ent.done = 1'b0;
        sbq.push_back(ent);
      end
      busy_until = e_m + int'(A_L) + int'(A_GAP) - 1;
      n_acc++;
    end
    cyc++;
  end

  // Monitor: {serial, busy, done, ready} of instance A against the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_missed_bit: stamp %0d not presented (cycle %0d)", sbq[0].cyc, cyc);
        sbq.delete(0);
      end
      exp_v = {IDLE, 1'b0, 1'b0, (cyc > busy_until)};
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_v = {sbq[0].b, 1'b1, sbq[0].done, (cyc > busy_until)};
        sbq.delete(0);
      end
      check("a_stream{ser,busy,done,rdy}", {a_serial, a_busy, a_done, a_ready}, exp_v);
    end
  end

  // Random upstream: valid pulses and data_in churn, including mid-frame.
  always @(negedge clk) begin
    if (rand_on) begin
      #1;
      a_valid = ($urandom_range(0, 3) != 0);
      a_data  = W'($urandom);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_accept(output int e);
    int start;
    start = n_acc;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (n_acc != start) begin
        e = cyc;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL accept_timeout: got none expected accept within 40 cycles");
  endtask

  task automatic drain();
    repeat (A_L + A_GAP + 4) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
  endtask

  int          e1, e2, rel;
  logic [31:0] fb;

  initial begin
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_state", {a_serial, a_busy, a_done, a_ready}, {IDLE, 1'b0, 1'b0, 1'b1});
    check("b_reset_state", {b_serial, b_busy, b_done, b_ready}, {IDLE, 1'b0, 1'b0, 1'b1});
    @(negedge clk); #1;
    rst = 1'b1;
    mon_on = 1'b1;

    // Single frame 110 -> 1,1,0,1,1 then two gap bits; data_in changes after accept.
    a_valid = 1'b1; a_data = 3'b110;
    wait_accept(e1);
    a_valid = 1'b0; a_data = 3'b001;
    repeat (10) @(posedge clk);

    // data_valid held high: 101 then 011, accepts L+GAP+1 apart.
    @(negedge clk); #1;
    a_valid = 1'b1; a_data = 3'b101;
    wait_accept(e1);
    a_data = 3'b011;
    wait_accept(e2);
    a_valid = 1'b0;
    check("b2b_accept_spacing", e2 - e1, A_L + A_GAP + 1);
    repeat (12) @(posedge clk);

    rand_on = 1'b1;
    repeat (1500) @(posedge clk);
    rand_on = 1'b0;
    @(negedge clk); #2;
    a_valid = 1'b0;
    drain();

    // Asynchronous reset part-way through a frame.
    @(negedge clk); #1;
    a_valid = 1'b1; a_data = W'($urandom);
    wait_accept(e1);
    a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    sbq.delete();
    busy_until = -100;
    #1;
    check("async_reset_mid_frame", {a_serial, a_busy, a_done, a_ready}, {IDLE, 1'b0, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    rel = cyc;
    a_valid = 1'b1; a_data = W'($urandom);
    wait_accept(e1);
    a_valid = 1'b0;
    check("first_accept_after_reset", e1, rel + 1);
    drain();

    // Instance B (even frame, no gap): 100 -> 1,0,0,0,0,1 then idle.
    fb = frame_bits(16'b100, W, B_ODD);
    @(negedge clk); #1;
    b_valid = 1'b1; b_data = 3'b100;
    @(posedge clk); #1;
    b_valid = 1'b0; b_data = 3'b011;
    for (int unsigned n = 0; n < 8; n++) begin
      @(negedge clk);
      check($sformatf("b_even_frame_n%0d", n), {b_serial, b_busy, b_done, b_ready},
            {((n >= 1 && n <= B_L) ? fb[n-1] : IDLE), (n >= 1 && n <= B_L),
             (n == B_L), (n >= B_L)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
